layer_mixer: RTL and testbench
==============================

# layer_mixer

Parametrised, pipelined video layer compositor for the display path. Takes NUM_LAYERS pixel sources (sprites, copper, starfield, etc.), each with an RGB value and a pixel_on key. Combines them over a background colour using per-layer modes (off, opaque, 50% blend, saturating add). Delays the sync/enable strobes so they stay aligned with the composited pixel. It replaces the fixed two-source select in the display top level. Mode and background changes are double-buffered and take effect only at the frame boundary, so a frame never tears.

## Interface

Parameters:
- NUM_LAYERS, 4, number of input layers; layer 0 is top priority, layer NUM_LAYERS-1 is bottom.
- COLOR_WIDTH, 8, bits per colour channel; a pixel is 3*COLOR_WIDTH bits, R in the MSBs.

Ports:
- pixel_clock  in  1  pixel clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- video_enable_in  in  1  active-area flag from video_sync.
- hsync_start_in  in  1  line-start strobe.
- vsync_start_in  in  1  frame-start strobe.
- layer_rgb  in  NUM_LAYERS*3*COLOR_WIDTH  layer i pixel at [i*3*COLOR_WIDTH +: 3*COLOR_WIDTH].
- layer_on  in  NUM_LAYERS  bit i high = layer i pixel is non-transparent.
- cfg_valid  in  1  one-cycle strobe; captures cfg_mode and cfg_bg.
- cfg_mode  in  2*NUM_LAYERS  layer i mode at [2i+:2]: 0 off, 1 opaque, 2 blend, 3 add.
- cfg_bg  in  3*COLOR_WIDTH  background colour.
- cfg_pending  out  1  high while a captured config awaits the next vsync.
- video_rgb  out  3*COLOR_WIDTH  composited pixel; 0 when blanked.
- video_enable  out  1  delayed video_enable_in.
- hsync_start  out  1  delayed hsync_start_in.
- vsync_start  out  1  delayed vsync_start_in.

## Operation

- All layer inputs and strobes are presented in the same cycle. Internally, layer i data is delayed to the stage that consumes it.
- Pipeline: stage k (k = 0..NUM_LAYERS-1) applies layer NUM_LAYERS-1-k over the accumulator. Stage 0 starts from the active background. The final output stage applies blanking and registers all outputs.
- Per-channel combine of top T over accumulator A, used only when the layer's layer_on=1 and its mode≠0; otherwise A passes through:
  - opaque: T.
  - blend: (T+A)>>1 with a COLOR_WIDTH+1-bit sum, truncating.
  - add: min(T+A, 2^COLOR_WIDTH-1).
- Blanking: video_rgb = 0 whenever the delayed video_enable is 0.
- Config double-buffering:
  - A cfg_valid edge loads the pending registers and sets cfg_pending.
  - On an edge where vsync_start_in=1 and cfg_pending=1, the pending values are copied to active and cfg_pending is cleared.
  - If cfg_valid and vsync_start_in are high on the same edge, the new config goes straight to active and cfg_pending=0.
  - A second cfg_valid before vsync overwrites pending (last write wins).
- Active config is sampled per pixel as it enters stage 0. The pixel accompanying vsync_start_in uses the old config. The first pixel after it uses the new config.

## Timing

- Latency: NUM_LAYERS+1 cycles from input to video_rgb, video_enable, hsync_start and vsync_start (5 cycles at default). All four outputs are delayed identically. Strobe widths are preserved.
- Throughput: one pixel per clock, no stalls, no backpressure.
- Reset (synchronous, dominates all other inputs):
  - Outputs: all outputs 0, cfg_pending 0.
  - Pipeline: all pipeline registers 0.
  - Config: active modes all 1 (opaque), active background 0, pending registers cleared.
- Reset asserted mid-frame: pipeline is flushed, pending config is discarded. For NUM_LAYERS+1 cycles after release, outputs are 0 / strobes low until valid data drains through.
- Arithmetic never wraps. Add saturates per channel independently.

## Test plan

- Reset/idle: hold reset 3 cycles, then feed enable=1, all layer_on=0, cfg_bg default → video_rgb=0, cfg_pending=0; outputs stay 0 for the first 5 cycles after release.
- Priority: modes all opaque; layer0=0xFF0000 on, layer2=0x00FF00 on → 0xFF0000 exactly 5 cycles later. Drop layer0 on → 0x00FF00.
- Arithmetic, with bg=0x202020 applied via cfg+vsync:
  - layer3 blend 0x808080 → 0x505050.
  - layer3 add 0xF0F0F0 → 0xFFFFFF.
  - layer3 add 0x101010 → 0x303030.
- Deferred config: cfg_valid mid-frame setting layer0 off → cfg_pending=1 and output still shows layer0. The pixel after the vsync_start_in cycle shows layer1; cfg_pending=0. A cfg_valid coinciding with vsync_start_in → applied next pixel, cfg_pending stays 0.
- Sync alignment: 1-cycle hsync/vsync pulses and an enable=0 window at input → identical 1-cycle pulses and window 5 cycles later; video_rgb=0 throughout the window.
- Reset mid-operation: pending config outstanding plus pipeline full, assert reset 1 cycle → next cycle all outputs 0, cfg_pending=0. After release, modes are opaque and bg=0 (layer0 0x123456 on → 0x123456).

Source files
------------

// File: rtl/layer_mixer.sv
// Layer compositor: one pixel per clock, fixed NUM_LAYERS+1 cycle latency, no backpressure.
// Stage k applies layer NUM_LAYERS-1-k over the accumulator; mode/bg changes land only at vsync.
module layer_mixer #(
  parameter int NUM_LAYERS  = 4,
  parameter int COLOR_WIDTH = 8
) (
  input  logic                                  pixel_clock,
  input  logic                                  reset,
  input  logic                                  video_enable_in,
  input  logic                                  hsync_start_in,
  input  logic                                  vsync_start_in,
  input  logic [NUM_LAYERS*3*COLOR_WIDTH-1:0]   layer_rgb,
  input  logic [NUM_LAYERS-1:0]                 layer_on,
  input  logic                                  cfg_valid,
  input  logic [2*NUM_LAYERS-1:0]               cfg_mode,
  input  logic [3*COLOR_WIDTH-1:0]              cfg_bg,
  output logic                                  cfg_pending,
  output logic [3*COLOR_WIDTH-1:0]              video_rgb,
  output logic                                  video_enable,
  output logic                                  hsync_start,
  output logic                                  vsync_start
);

  localparam int CW = COLOR_WIDTH;
  localparam int PW = 3 * COLOR_WIDTH;
  localparam int LW = PW + 3;  // {mode[1:0], on, rgb}

  logic [2*NUM_LAYERS-1:0] act_mode, pend_mode;
  logic [PW-1:0]           act_bg, pend_bg;

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      act_mode    <= {NUM_LAYERS{2'b01}};
      act_bg      <= '0;
      pend_mode   <= '0;
      pend_bg     <= '0;
      cfg_pending <= 1'b0;
    end else if (cfg_valid && vsync_start_in) begin
      act_mode    <= cfg_mode;
      act_bg      <= cfg_bg;
      cfg_pending <= 1'b0;
    end else if (cfg_valid) begin
      pend_mode   <= cfg_mode;
      pend_bg     <= cfg_bg;
      cfg_pending <= 1'b1;
    end else if (vsync_start_in && cfg_pending) begin
      act_mode    <= pend_mode;
      act_bg      <= pend_bg;
      cfg_pending <= 1'b0;
    end
  end

  // Each layer travels with the mode that was active when its pixel entered stage 0.
  logic [LW-1:0] tap [NUM_LAYERS];

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    localparam int D = NUM_LAYERS - 1 - i;
    logic [LW-1:0] cur;
    assign cur = {act_mode[2*i +: 2], layer_on[i], layer_rgb[i*PW +: PW]};
    if (D == 0) begin : g_direct
      assign tap[i] = cur;
    end else begin : g_delay
      logic [LW-1:0] sr [D];
      always_ff @(posedge pixel_clock) begin
        if (reset) begin
          for (int j = 0; j < D; j++) sr[j] <= '0;
        end else begin
          sr[0] <= cur;
          for (int j = 1; j < D; j++) sr[j] <= sr[j-1];
        end
      end
      assign tap[i] = sr[D-1];
    end
  end

  function automatic logic [PW-1:0] mix(input logic [LW-1:0] t, input logic [PW-1:0] a);
    logic [CW:0] s;
    mix = a;
    if (t[PW] && (t[LW-1 -: 2] != 2'd0)) begin
      for (int c = 0; c < 3; c++) begin
        s = {1'b0, t[c*CW +: CW]} + {1'b0, a[c*CW +: CW]};
        case (t[LW-1 -: 2])
          2'd1:    mix[c*CW +: CW] = t[c*CW +: CW];
          2'd2:    mix[c*CW +: CW] = s[CW:1];
          default: mix[c*CW +: CW] = s[CW] ? {CW{1'b1}} : s[CW-1:0];
        endcase
      end
    end
  endfunction

  logic [PW-1:0] acc [NUM_LAYERS];
  logic [2:0]    sp  [NUM_LAYERS];  // {enable, hsync, vsync}

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_LAYERS; k++) begin
        acc[k] <= '0;
        sp[k]  <= '0;
      end
      video_rgb    <= '0;
      video_enable <= 1'b0;
      hsync_start  <= 1'b0;
      vsync_start  <= 1'b0;
    end else begin
      acc[0] <= mix(tap[NUM_LAYERS-1], act_bg);
      sp[0]  <= {video_enable_in, hsync_start_in, vsync_start_in};
      for (int k = 1; k < NUM_LAYERS; k++) begin
        acc[k] <= mix(tap[NUM_LAYERS-1-k], acc[k-1]);
        sp[k]  <= sp[k-1];
      end
      video_rgb    <= sp[NUM_LAYERS-1][2] ? acc[NUM_LAYERS-1] : '0;
      video_enable <= sp[NUM_LAYERS-1][2];
      hsync_start  <= sp[NUM_LAYERS-1][1];
      vsync_start  <= sp[NUM_LAYERS-1][0];
    end
  end

endmodule

// File: tb/tb_layer_mixer.sv
// Bench for layer_mixer: directed steps plus random traffic against a per-pixel reference model.
module tb_layer_mixer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0, hs = 1'b0, vs = 1'b0;
  logic [95:0] lrgb = '0;
  logic [3:0]  lon = '0;
  logic        cfg_valid = 1'b0;
  logic [7:0]  cfg_mode = 8'h55;
  logic [23:0] cfg_bg = '0;
  logic        cfg_pending;
  logic [23:0] video_rgb;
  logic        video_enable, hsync_start, vsync_start;

  always #5 clk = ~clk;

  layer_mixer #(.NUM_LAYERS(4), .COLOR_WIDTH(8)) dut (
    .pixel_clock(clk), .reset(reset),
    .video_enable_in(en), .hsync_start_in(hs), .vsync_start_in(vs),
    .layer_rgb(lrgb), .layer_on(lon),
    .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_bg(cfg_bg),
    .cfg_pending(cfg_pending), .video_rgb(video_rgb),
    .video_enable(video_enable), .hsync_start(hsync_start), .vsync_start(vsync_start)
  );

  typedef struct packed {
    logic [23:0] rgb;
    logic        en, hs, vs;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  m_mode = 8'h55, p_mode = '0;
  logic [23:0] m_bg = '0, p_bg = '0;
  logic        m_pend = 1'b0;
  int          checks = 0, passes = 0, fails = 0;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Layers composited bottom to top over the background, whole-number arithmetic per channel.
  function automatic logic [23:0] ref_pix(input logic [95:0] rgb, input logic [3:0] on);
    int a[3];
    int t, s, md;
    logic [23:0] r;
    for (int c = 0; c < 3; c++) a[c] = int'(m_bg[c*8 +: 8]);
    for (int i = 3; i >= 0; i--) begin
      md = int'(m_mode[2*i +: 2]);
      if (on[i] && md != 0) begin
        for (int c = 0; c < 3; c++) begin
          t = int'(rgb[i*24 + c*8 +: 8]);
          if (md == 1) a[c] = t;
          else if (md == 2) a[c] = (t + a[c]) / 2;
          else begin
            s = t + a[c];
            a[c] = (s > 255) ? 255 : s;
          end
        end
      end
    end
    for (int c = 0; c < 3; c++) r[c*8 +: 8] = 8'(a[c]);
    return r;
  endfunction

  task automatic cyc();
    exp_t e;
    if (reset) begin
      q.delete();
      m_mode = 8'h55; m_bg = '0; p_mode = '0; p_bg = '0; m_pend = 1'b0;
    end else begin
      e.rgb = en ? ref_pix(lrgb, lon) : 24'h0;
      e.en = en; e.hs = hs; e.vs = vs;
      q.push_back(e);
      if (cfg_valid && vs) begin
        m_mode = cfg_mode; m_bg = cfg_bg; m_pend = 1'b0;
      end else if (cfg_valid) begin
        p_mode = cfg_mode; p_bg = cfg_bg; m_pend = 1'b1;
      end else if (vs && m_pend) begin
        m_mode = p_mode; m_bg = p_bg; m_pend = 1'b0;
      end
    end
    @(posedge clk); #1;
    if (reset || q.size() < 5) e = '0;
    else e = q.pop_front();
    check("rgb", video_rgb, e.rgb);
    check("enable", {23'd0, video_enable}, {23'd0, e.en});
    check("hsync", {23'd0, hsync_start}, {23'd0, e.hs});
    check("vsync", {23'd0, vsync_start}, {23'd0, e.vs});
    check("pending", {23'd0, cfg_pending}, {23'd0, m_pend});
  endtask

  task automatic set_layer(input int i, input logic [23:0] v);
    lrgb[i*24 +: 24] = v;
  endtask

  task automatic apply_cfg_now(input logic [7:0] md, input logic [23:0] bg);
    cfg_valid = 1'b1; cfg_mode = md; cfg_bg = bg; vs = 1'b1;
    cyc();
    cfg_valid = 1'b0; vs = 1'b0;
    check("cfg_with_vsync_pending", {23'd0, cfg_pending}, 24'd0);
  endtask

  initial begin
    // Reset and idle
    repeat (3) cyc();
    check("reset_rgb", video_rgb, 24'h0);
    check("reset_pending", {23'd0, cfg_pending}, 24'd0);
    reset = 1'b0; en = 1'b1;
    repeat (5) begin
      cyc();
      check("idle_rgb", video_rgb, 24'h0);
    end

    // Priority: layer0 over layer2, appearing exactly five cycles later
    set_layer(0, 24'hFF0000); set_layer(2, 24'h00FF00); lon = 4'b0101;
    repeat (4) cyc();
    check("prio_early", video_rgb, 24'h0);
    cyc();
    check("prio_top", video_rgb, 24'hFF0000);
    lon = 4'b0100;
    repeat (5) cyc();
    check("prio_drop_top", video_rgb, 24'h00FF00);

    // Arithmetic over bg 0x202020
    apply_cfg_now(8'h95, 24'h202020);
    lon = 4'b1000; set_layer(3, 24'h808080);
    repeat (5) cyc();
    check("blend", video_rgb, 24'h505050);
    apply_cfg_now(8'hD5, 24'h202020);
    set_layer(3, 24'hF0F0F0);
    repeat (5) cyc();
    check("add_sat", video_rgb, 24'hFFFFFF);
    set_layer(3, 24'h101010);
    repeat (5) cyc();
    check("add_nosat", video_rgb, 24'h303030);

    // Deferred config: layer0 turned off mid-frame
    apply_cfg_now(8'h55, 24'h202020);
    lon = 4'b0011; set_layer(0, 24'hAA0000); set_layer(1, 24'h0000BB);
    repeat (5) cyc();
    check("defer_before", video_rgb, 24'hAA0000);
    cfg_valid = 1'b1; cfg_mode = 8'h54;
    cyc();
    cfg_valid = 1'b0;
    check("defer_pending", {23'd0, cfg_pending}, 24'd1);
    repeat (5) cyc();
    check("defer_still_old", video_rgb, 24'hAA0000);
    vs = 1'b1;
    cyc();
    vs = 1'b0;
    repeat (3) cyc();
    cyc();
    check("defer_vsync_pixel", video_rgb, 24'hAA0000);
    check("defer_vsync_out", {23'd0, vsync_start}, 24'd1);
    cyc();
    check("defer_applied", video_rgb, 24'h0000BB);
    check("defer_cleared", {23'd0, cfg_pending}, 24'd0);

    // Sync alignment with a blanking window
    hs = 1'b1;
    cyc();
    hs = 1'b0; en = 1'b0;
    repeat (3) cyc();
    en = 1'b1;
    cyc();
    check("hsync_aligned", {23'd0, hsync_start}, 24'd1);
    cyc();
    check("hsync_width", {23'd0, hsync_start}, 24'd0);
    check("blank_enable", {23'd0, video_enable}, 24'd0);
    check("blank_rgb", video_rgb, 24'h0);
    repeat (4) cyc();

    // Reset with pending config and a full pipeline
    cfg_valid = 1'b1; cfg_mode = 8'h00; cfg_bg = 24'hFFFFFF;
    cyc();
    cfg_valid = 1'b0;
    check("midreset_pending_before", {23'd0, cfg_pending}, 24'd1);
    reset = 1'b1; hs = 1'b1;
    cyc();
    check("midreset_rgb", video_rgb, 24'h0);
    check("midreset_enable", {23'd0, video_enable}, 24'd0);
    check("midreset_pending", {23'd0, cfg_pending}, 24'd0);
    reset = 1'b0; hs = 1'b0;
    lon = 4'b0001; set_layer(0, 24'h123456);
    repeat (5) cyc();
    check("after_reset_defaults", video_rgb, 24'h123456);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      lrgb      = {$urandom, $urandom, $urandom};
      lon       = 4'($urandom);
      en        = ($urandom_range(0, 7) != 0);
      hs        = ($urandom_range(0, 15) == 0);
      vs        = ($urandom_range(0, 23) == 0);
      cfg_valid = ($urandom_range(0, 15) == 0);
      cfg_mode  = 8'($urandom);
      cfg_bg    = 24'($urandom);
      reset     = ($urandom_range(0, 99) == 0);
      cyc();
    end
    reset = 1'b0; cfg_valid = 1'b0; vs = 1'b0; hs = 1'b0;
    repeat (6) cyc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
